// File: rtl/gpio_clk_monitor.sv
// Measures the period of a square wave on one selected GPIO input and reports lock when
// the period stays within tolerance of a programmed expectation for LOCK_COUNT periods.
module gpio_clk_monitor #(
    parameter int BASE        = 0,
    parameter int WIDTH       = 10,
    parameter int SYNC_STAGES = 2,
    parameter int LOCK_COUNT  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             set_stb,
    input  logic [7:0]       set_addr,
    input  logic [31:0]      set_data,
    input  logic [WIDTH-1:0] gpio_in,
    output logic             edge_stb,
    output logic             locked,
    output logic [31:0]      rb_data
);
    typedef enum logic [1:0] {DISABLED, ACQUIRE, TRACK, LOCKED} state_t;

    logic [4:0]  ctrl_q, ctrl_d;
    logic [15:0] expected_q, expected_d;
    logic [7:0]  tol_q, tol_d;
    logic [15:0] timeout_q, timeout_d;
    logic        wr_ctrl, clr_lost, ctrl_changed, enable;

    logic                   sel_pin;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise_q, rise_d;
    logic                   edge_stb_q, edge_stb_d;

    state_t      state_q, state_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [15:0] period_q, period_d;
    logic [7:0]  edge_cnt_q, edge_cnt_d;
    logic [7:0]  good_cnt_q, good_cnt_d, good_inc;
    logic        locked_q, locked_d;
    logic        lost_q, lost_d, loss;
    logic [31:0] rb_data_q, rb_data_d;
    logic [16:0] diff, abs_diff;
    logic        good, timed_out;

    always_comb begin
        ctrl_d     = ctrl_q;
        expected_d = expected_q;
        tol_d      = tol_q;
        timeout_d  = timeout_q;
        wr_ctrl    = set_stb && (set_addr == 8'(BASE));
        if (wr_ctrl) ctrl_d = set_data[4:0];
        if (set_stb && (set_addr == 8'(BASE + 1))) expected_d = set_data[15:0];
        if (set_stb && (set_addr == 8'(BASE + 2))) tol_d = set_data[7:0];
        if (set_stb && (set_addr == 8'(BASE + 3))) timeout_d = set_data[15:0];
        clr_lost     = wr_ctrl && set_data[5];
        // Only a write that alters pin_sel/enable restarts acquisition; a pure clr_lost write does not
        ctrl_changed = wr_ctrl && (set_data[4:0] != ctrl_q);
        enable       = ctrl_d[4];
    end

    always_comb begin
        sel_pin = 1'b0;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            if (32'(ctrl_q[3:0]) == i) sel_pin = gpio_in[i];
        end
        sync_d     = {sync_q[SYNC_STAGES-2:0], sel_pin};
        prev_d     = sync_q[SYNC_STAGES-1];
        rise_d     = sync_q[SYNC_STAGES-1] & ~prev_q;
        edge_stb_d = rise_q;
    end

    always_comb begin
        cnt_inc   = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;
        good_inc  = (good_cnt_q == 8'hFF) ? good_cnt_q : good_cnt_q + 8'd1;
        diff      = {1'b0, cnt_inc} - {1'b0, expected_q};
        abs_diff  = diff[16] ? (~diff + 17'd1) : diff;
        good      = abs_diff <= {9'd0, tol_q};
        timed_out = (timeout_q != 16'd0) && !rise_q && (cnt_inc == timeout_q);

        state_d    = state_q;
        cnt_d      = rise_q ? 16'd0 : cnt_inc;
        period_d   = period_q;
        edge_cnt_d = edge_cnt_q + {7'd0, rise_q};
        good_cnt_d = good_cnt_q;
        loss       = 1'b0;

        case (state_q)
            DISABLED: begin
                state_d = ACQUIRE;
                cnt_d   = '0;
            end
            ACQUIRE: begin
                good_cnt_d = '0;
                if (rise_q) state_d = TRACK;
            end
            TRACK: begin
                if (rise_q) begin
                    period_d = cnt_inc;
                    if (good) begin
                        good_cnt_d = good_inc;
                        if (good_inc >= 8'(LOCK_COUNT)) state_d = LOCKED;
                    end else begin
                        good_cnt_d = '0;
                    end
                end else if (timed_out) begin
                    state_d    = ACQUIRE;
                    good_cnt_d = '0;
                end
            end
            default: begin
                if (rise_q) begin
                    period_d   = cnt_inc;
                    good_cnt_d = good_inc;
                    if (!good) begin
                        state_d    = ACQUIRE;
                        good_cnt_d = '0;
                        loss       = 1'b1;
                    end
                end else if (timed_out) begin
                    state_d    = ACQUIRE;
                    good_cnt_d = '0;
                    loss       = 1'b1;
                end
            end
        endcase

        if (!enable) begin
            state_d    = DISABLED;
            cnt_d      = '0;
            period_d   = '0;
            edge_cnt_d = '0;
            good_cnt_d = '0;
        end else if (ctrl_changed && state_q != DISABLED) begin
            state_d    = ACQUIRE;
            good_cnt_d = '0;
        end

        // A loss in the same cycle as clr_lost leaves the flag set
        lost_d    = loss ? 1'b1 : (clr_lost ? 1'b0 : lost_q);
        locked_d  = (state_d == LOCKED);
        rb_data_d = {enable, locked_d, lost_d, 5'b0, edge_cnt_d, period_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            expected_q <= '0;
            tol_q      <= '0;
            timeout_q  <= '0;
            sync_q     <= '0;
            prev_q     <= 1'b0;
            rise_q     <= 1'b0;
            edge_stb_q <= 1'b0;
            state_q    <= DISABLED;
            cnt_q      <= '0;
            period_q   <= '0;
            edge_cnt_q <= '0;
            good_cnt_q <= '0;
            locked_q   <= 1'b0;
            lost_q     <= 1'b0;
            rb_data_q  <= '0;
        end else begin
            ctrl_q     <= ctrl_d;
            expected_q <= expected_d;
            tol_q      <= tol_d;
            timeout_q  <= timeout_d;
            sync_q     <= sync_d;
            prev_q     <= prev_d;
            rise_q     <= rise_d;
            edge_stb_q <= edge_stb_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            period_q   <= period_d;
            edge_cnt_q <= edge_cnt_d;
            good_cnt_q <= good_cnt_d;
            locked_q   <= locked_d;
            lost_q     <= lost_d;
            rb_data_q  <= rb_data_d;
        end
    end

    assign edge_stb = edge_stb_q;
    assign locked   = locked_q;
    assign rb_data  = rb_data_q;
endmodule
